// File: rtl/instr_encoder_loader_pkg.sv
// Shared LEGv8 encoding definitions: op-select codes, opcode constants (the same
// values the decoder matches), loader states and the field-packer result type.
package instr_encoder_loader_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_ORR  = 3'd3,
      OP_LDUR = 3'd4,
      OP_STUR = 3'd5,
      OP_CBZ  = 3'd6,
      OP_B    = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
   localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
   localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
   localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;
   localparam logic [5:0]  OPC_B    = 6'b00_0101;

   typedef struct packed {
      logic [31:0] word;
      logic        range_err;
   } pack_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Op stream from the host plus the instruction-memory write port of the loader.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2:0]              in_op;
   logic [4:0]              in_rd;
   logic [4:0]              in_rn;
   logic [4:0]              in_rm;
   logic signed [25:0]      in_imm;
   logic                    in_last;
   logic                    imem_we;
   logic [ADDR_W-1:0]       imem_addr;
   logic [31:0]             imem_wdata;

   modport master (
      output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader_field_pack.sv
// Combinational packer: symbolic op + register fields + immediate -> 32-bit
// LEGv8 word, flagging immediates that do not fit the target format.
module instr_encoder_loader_field_pack
   import instr_encoder_loader_pkg::*;
(
   input  op_e                op,
   input  logic [4:0]         rd,
   input  logic [4:0]         rn,
   input  logic [4:0]         rm,
   input  logic signed [25:0] imm,
   output pack_t              pk
);

   // A value fits a narrower signed field when every bit above it copies its sign.
   function automatic logic fits_d(input logic signed [25:0] v);
      return v[25:8] == {18{v[8]}};
   endfunction

   function automatic logic fits_cb(input logic signed [25:0] v);
      return v[25:18] == {8{v[18]}};
   endfunction

   always_comb begin
      pk = '0;
      case (op)
         OP_ADD:  pk.word = {OPC_ADD, rm, 6'd0, rn, rd};
         OP_SUB:  pk.word = {OPC_SUB, rm, 6'd0, rn, rd};
         OP_AND:  pk.word = {OPC_AND, rm, 6'd0, rn, rd};
         OP_ORR:  pk.word = {OPC_ORR, rm, 6'd0, rn, rd};
         OP_LDUR: begin
            pk.word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            pk.range_err = !fits_d(imm);
         end
         OP_STUR: begin
            pk.word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            pk.range_err = !fits_d(imm);
         end
         OP_CBZ: begin
            pk.word      = {OPC_CBZ, imm[18:0], rd};
            pk.range_err = !fits_cb(imm);
         end
         OP_B:    pk.word = {OPC_B, imm};
         default: pk = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loader top: accepts encoded ops one per cycle and writes them to consecutive
// imem words from BASE_ADDR, with one cycle of latency to the write strobe.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 64
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   instr_encoder_loader_if.slave        bus,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [$clog2(DEPTH+1)-1:0]   word_count
);

   localparam int CW = $clog2(DEPTH+1);

   state_e             state_q;
   state_e             state_d;
   pack_t              pk;
   logic               accept;
   logic               vld_p1;
   logic               err_p1;
   logic [ADDR_W-1:0]  addr_p1;
   logic [31:0]        wdata_p1;
   logic [CW-1:0]      count_q;
   logic [ADDR_W-1:0]  next_addr;

   instr_encoder_loader_field_pack u_pack (
      .op  (op_e'(bus.in_op)),
      .rd  (bus.in_rd),
      .rn  (bus.in_rn),
      .rm  (bus.in_rm),
      .imm (bus.in_imm),
      .pk  (pk)
   );

   // A start in the same cycle as a handshake wins; the op is dropped.
   assign accept    = bus.in_valid && bus.in_ready && !start;
   assign next_addr = ADDR_W'(BASE_ADDR + 4 * int'(count_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (start)                      state_d = ST_LOAD;
            else if (accept && bus.in_last) state_d = ST_DONE;
         end
         ST_DONE: if (start) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      bus.in_ready = 1'b0;
      case (state_q)
         ST_LOAD: begin
            busy         = 1'b1;
            bus.in_ready = count_q < CW'(DEPTH);
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // p0 -> p1: packed word and write/reject strobes registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         addr_p1  <= ADDR_W'(BASE_ADDR);
         wdata_p1 <= '0;
         count_q  <= '0;
      end else begin
         vld_p1 <= accept && !pk.range_err;
         err_p1 <= accept && pk.range_err;
         if (start) begin
            count_q <= '0;
            addr_p1 <= ADDR_W'(BASE_ADDR);
         end else if (accept && !pk.range_err) begin
            addr_p1  <= next_addr;
            wdata_p1 <= pk.word;
            count_q  <= count_q + CW'(1);
         end
      end
   end

   assign bus.imem_we    = vld_p1;
   assign bus.imem_addr  = addr_p1;
   assign bus.imem_wdata = wdata_p1;
   assign err            = err_p1;
   assign word_count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: session-level reference model checked
// every cycle, plus hand-computed instruction words at key points.
module tb_instr_encoder_loader;

   localparam int ADDR_W    = 8;
   localparam int BASE_ADDR = 0;
   localparam int DEPTH     = 4;
   localparam int CW        = $clog2(DEPTH+1);

   localparam int ADD = 0, SUB = 1, AND = 2, ORR = 3, LDUR = 4, STUR = 5, CBZ = 6, BR = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, err;
   logic [CW-1:0] word_count;

   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference encoding built from field weights rather than bit concatenation.
   function automatic logic [31:0] enc(input longint op, input longint rd, input longint rn,
                                       input longint rm, input longint imm);
      longint r, opc, d9, c19, b26;
      d9  = ((imm % 512) + 512) % 512;
      c19 = ((imm % 524288) + 524288) % 524288;
      b26 = ((imm % 67108864) + 67108864) % 67108864;
      case (op)
         0, 1, 2, 3: begin
            opc = (op == 0) ? 1112 : (op == 1) ? 1624 : (op == 2) ? 1104 : 1360;
            r   = opc * 2097152 + rm * 65536 + rn * 32 + rd;
         end
         4, 5: begin
            opc = (op == 4) ? 1986 : 1984;
            r   = opc * 2097152 + d9 * 4096 + rn * 32 + rd;
         end
         6:       r = longint'(180) * 16777216 + c19 * 32 + rd;
         default: r = longint'(5) * 67108864 + b26;
      endcase
      return r[31:0];
   endfunction

   function automatic bit fits(input int op, input int imm);
      if (op == LDUR || op == STUR) return (imm >= -256) && (imm <= 255);
      if (op == CBZ)                return (imm >= -262144) && (imm <= 262143);
      return 1'b1;
   endfunction

   bit     m_loading = 1'b0;
   bit     m_done    = 1'b0;
   int     m_count   = 0;
   bit     e_we      = 1'b0;
   bit     e_err     = 1'b0;
   int     e_addr    = BASE_ADDR;
   logic [31:0] e_wdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading = 1'b0; m_done = 1'b0; m_count = 0;
         e_we = 1'b0; e_err = 1'b0; e_addr = BASE_ADDR; e_wdata = '0;
      end else begin
         e_we  = 1'b0;
         e_err = 1'b0;
         if (start) begin
            m_loading = 1'b1; m_done = 1'b0; m_count = 0; e_addr = BASE_ADDR;
         end else if (m_loading && bus.in_valid && m_count < DEPTH) begin
            if (fits(int'(bus.in_op), int'(bus.in_imm))) begin
               e_we    = 1'b1;
               e_addr  = BASE_ADDR + 4 * m_count;
               e_wdata = enc(longint'(bus.in_op), longint'(bus.in_rd), longint'(bus.in_rn),
                             longint'(bus.in_rm), longint'(bus.in_imm));
               m_count++;
            end else begin
               e_err = 1'b1;
            end
            if (bus.in_last) begin
               m_loading = 1'b0; m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("we", 64'(bus.imem_we), 64'(e_we));
         chk("err", 64'(err), 64'(e_err));
         chk("addr", 64'(bus.imem_addr), 64'(e_addr));
         chk("count", 64'(word_count), 64'(m_count));
         chk("busy", 64'(busy), 64'(m_loading));
         chk("done", 64'(done), 64'(m_done));
         chk("ready", 64'(bus.in_ready), 64'(m_loading && m_count < DEPTH));
         if (e_we) chk("wdata", 64'(bus.imem_wdata), 64'(e_wdata));
      end
   end

   task automatic drive(input bit st, input bit v, input int op, input int rd, input int rn,
                        input int rm, input int imm, input bit last);
      @(negedge clk);
      start        = st;
      bus.in_valid = v;
      bus.in_op    = 3'(op);
      bus.in_rd    = 5'(rd);
      bus.in_rn    = 5'(rn);
      bus.in_rm    = 5'(rm);
      bus.in_imm   = 26'(imm);
      bus.in_last  = last;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0;
      bus.in_rm = '0; bus.in_imm = '0; bus.in_last = 1'b0;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_we", 64'(bus.imem_we), 64'd0);
      chk("rst_addr", 64'(bus.imem_addr), 64'(BASE_ADDR));
      chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
      chk("rst_count", 64'(word_count), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b1;

      // back-to-back R/D/CB/B ops, last one closes the session
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, ADD, 1, 2, 3, 0, 0);
      drive(0, 1, LDUR, 9, 10, 0, 8, 0);
      chk("add_word", 64'(bus.imem_wdata), 64'h8B030041);
      chk("add_addr", 64'(bus.imem_addr), 64'h00);
      chk("add_count", 64'(word_count), 64'd1);
      drive(0, 1, CBZ, 5, 0, 0, -2, 0);
      chk("ldur_word", 64'(bus.imem_wdata), 64'hF8408149);
      chk("ldur_addr", 64'(bus.imem_addr), 64'h04);
      chk("ldur_we", 64'(bus.imem_we), 64'd1);
      drive(0, 1, BR, 0, 0, 0, 4, 1);
      chk("cbz_word", 64'(bus.imem_wdata), 64'hB4FFFFC5);
      idle();
      chk("b_word", 64'(bus.imem_wdata), 64'h14000004);
      chk("b_done", 64'(done), 64'd1);
      chk("b_busy", 64'(busy), 64'd0);
      chk("b_ready", 64'(bus.in_ready), 64'd0);

      // out-of-range immediates are rejected without consuming an address
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, STUR, 7, 8, 0, 256, 0);
      drive(0, 1, STUR, 7, 8, 0, -256, 0);
      chk("stur_err", 64'(err), 64'd1);
      chk("stur_we", 64'(bus.imem_we), 64'd0);
      chk("stur_count", 64'(word_count), 64'd0);
      drive(0, 1, CBZ, 3, 0, 0, 262144, 0);
      chk("stur2_word", 64'(bus.imem_wdata), 64'hF8100107);
      chk("stur2_addr", 64'(bus.imem_addr), 64'h00);
      drive(0, 1, SUB, 4, 5, 6, 0, 0);
      chk("cbz_err", 64'(err), 64'd1);
      drive(0, 1, LDUR, 2, 3, 0, -257, 1);
      chk("sub_word", 64'(bus.imem_wdata), 64'hCB0600A4);
      chk("sub_addr", 64'(bus.imem_addr), 64'h04);
      idle();
      chk("rej_last_done", 64'(done), 64'd1);

      // overfill: only DEPTH words land, then the stream stalls
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) drive(0, 1, ORR, i, i + 1, i + 2, 0, 0);
      idle();
      idle();
      chk("full_ready", 64'(bus.in_ready), 64'd0);
      chk("full_count", 64'(word_count), 64'd4);
      chk("full_addr", 64'(bus.imem_addr), 64'h0C);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      chk("restart_count", 64'(word_count), 64'd0);
      chk("restart_addr", 64'(bus.imem_addr), 64'(BASE_ADDR));

      // start beside a handshake drops the op; then async reset mid-burst
      drive(0, 1, ADD, 1, 1, 1, 0, 0);
      drive(0, 1, ADD, 2, 2, 2, 0, 0);
      drive(1, 1, ADD, 3, 3, 3, 0, 0);
      idle();
      chk("startwin_we", 64'(bus.imem_we), 64'd0);
      chk("startwin_count", 64'(word_count), 64'd0);
      drive(0, 1, AND, 4, 4, 4, 0, 0);
      drive(0, 1, SUB, 5, 5, 5, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we", 64'(bus.imem_we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_count", 64'(word_count), 64'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, ADD, 1, 2, 3, 0, 0);
      idle();
      chk("resume_addr", 64'(bus.imem_addr), 64'(BASE_ADDR));
      chk("resume_word", 64'(bus.imem_wdata), 64'h8B030041);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
